// File: rtl/in_wait_ctrl.sv
// rtl/in_wait_ctrl.sv - PC stall controller for the IN instruction with button sync/debounce
module in_wait_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DATA_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_in_instr,
    input  logic                  halt_req,
    input  logic                  enter_btn,
    input  logic [DATA_WIDTH-1:0] switches,
    output logic                  pc_hold,
    output logic                  in_valid,
    output logic [31:0]           in_data,
    output logic                  btn_level,
    output logic [2:0]            state
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        RUN          = 3'd0,
        WAIT_PRESS   = 3'd1,
        ACCEPT       = 3'd2,
        WAIT_RELEASE = 3'd3,
        HALTED       = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             sync1;
    logic             sync2;
    logic             btn_prev;
    logic             press;
    logic             load_data;
    logic [CNT_W-1:0] db_cnt;

    // Level flips only after sync2 has disagreed with it for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            btn_level <= 1'b0;
            btn_prev  <= 1'b0;
            db_cnt    <= '0;
        end else begin
            sync1    <= enter_btn;
            sync2    <= sync1;
            btn_prev <= btn_level;
            if (sync2 == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                btn_level <= sync2;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = btn_level & ~btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            in_data <= 32'd0;
        end else begin
            state_q <= state_d;
            if (load_data) begin
                in_data <= 32'(switches);
            end
        end
    end

    // A held button cannot satisfy WAIT_PRESS: only a fresh rising edge of btn_level counts
    always_comb begin
        state_d   = state_q;
        pc_hold   = halt_req | is_in_instr;
        load_data = 1'b0;
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (is_in_instr) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                pc_hold = 1'b1;
                if (halt_req) begin
                    state_d = HALTED;
                end else if (press) begin
                    state_d   = ACCEPT;
                    load_data = 1'b1;
                end
            end
            ACCEPT: begin
                pc_hold = 1'b0;
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (!btn_level) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                pc_hold = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign in_valid = (state_q == ACCEPT);
    assign state    = state_q;
endmodule

// File: tb/tb_in_wait_ctrl.sv
// tb/tb_in_wait_ctrl.sv - self-checking bench for in_wait_ctrl against a window-based reference model
module tb_in_wait_ctrl;
    localparam int D  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          is_in_instr = 1'b0;
    logic          halt_req = 1'b0;
    logic          enter_btn = 1'b0;
    logic [DW-1:0] switches = '0;
    logic          pc_hold;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          btn_level;
    logic [2:0]    state;

    in_wait_ctrl #(.DEBOUNCE_CYCLES(D), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .is_in_instr(is_in_instr),
        .halt_req   (halt_req),
        .enter_btn  (enter_btn),
        .switches   (switches),
        .pc_hold    (pc_hold),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .btn_level  (btn_level),
        .state      (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int obs_valid = 0;

    int          m_st;
    bit          m_lvl;
    bit          m_prev;
    logic [31:0] m_data;
    bit          raw_q[$];
    bit          s2_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Button level changes when the last D synchronised samples all disagree with it
    task automatic model_edge();
        bit s2;
        bit press;
        bit flip;
        if (reset) begin
            m_st = 0; m_lvl = 0; m_prev = 0; m_data = 32'd0;
            raw_q.delete(); s2_q.delete();
            return;
        end
        press = m_lvl && !m_prev;
        s2 = (raw_q.size() == 2) ? raw_q[0] : 1'b0;
        raw_q.push_back(enter_btn);
        if (raw_q.size() > 2) raw_q.delete(0);
        s2_q.push_back(s2);
        if (s2_q.size() > D) s2_q.delete(0);
        flip = (s2_q.size() == D);
        foreach (s2_q[j]) if (s2_q[j] == m_lvl) flip = 0;
        case (m_st)
            0: m_st = halt_req ? 4 : (is_in_instr ? 1 : 0);
            1: if (halt_req) m_st = 4;
               else if (press) begin m_st = 2; m_data = 32'(switches); end
            2: m_st = 3;
            3: m_st = halt_req ? 4 : (m_lvl ? 3 : 0);
            default: m_st = 4;
        endcase
        m_prev = m_lvl;
        if (flip) m_lvl = !m_lvl;
    endtask

    function automatic bit exp_hold();
        if (m_st == 1 || m_st == 4) return 1'b1;
        if (m_st == 2) return 1'b0;
        return halt_req | is_in_instr;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        if (in_valid === 1'b1) obs_valid++;
        chk("state", 32'(state), 32'(m_st));
        chk("pc_hold", 32'(pc_hold), 32'(exp_hold()));
        chk("in_valid", 32'(in_valid), 32'(m_st == 2));
        chk("in_data", in_data, m_data);
        chk("btn_level", 32'(btn_level), 32'(m_lvl));
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && state !== 3'(target); i++) tick();
        chk(tag, 32'(state), 32'(target));
    endtask

    initial begin
        // Reset and idle
        do_reset();
        repeat (20) tick();
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_hold", 32'(pc_hold), 32'd0);
        chk("idle_valid", 32'(in_valid), 32'd0);
        chk("idle_data", in_data, 32'h0);

        // Single accept of 0xBEEF
        do_reset();
        is_in_instr = 1'b1; switches = 16'hBEEF;
        #1 chk("in_hold_comb", 32'(pc_hold), 32'd1);
        repeat (8) tick();
        enter_btn = 1'b1; obs_valid = 0;
        wait_state(3, 30, "accept_to_release");
        chk("accept_count", 32'(obs_valid), 32'd1);
        chk("accept_data", in_data, 32'h0000BEEF);
        is_in_instr = 1'b0; enter_btn = 1'b0;
        wait_state(0, 20, "release_to_run");

        // Short glitch ignored, D-cycle glitch accepted
        is_in_instr = 1'b1; switches = 16'h0A5A;
        tick(); tick();
        enter_btn = 1'b1; repeat (3) tick();
        enter_btn = 1'b0; obs_valid = 0; repeat (8) tick();
        chk("glitch_level", 32'(btn_level), 32'd0);
        chk("glitch_state", 32'(state), 32'd1);
        chk("glitch_count", 32'(obs_valid), 32'd0);
        enter_btn = 1'b1; repeat (4) tick();
        enter_btn = 1'b0; repeat (6) tick();
        chk("long_glitch_count", 32'(obs_valid), 32'd1);
        repeat (10) tick();

        // Back-to-back IN with button held: one accept until re-pressed
        switches = 16'h1111; enter_btn = 1'b1; obs_valid = 0;
        repeat (30) tick();
        chk("held_count", 32'(obs_valid), 32'd1);
        enter_btn = 1'b0; repeat (10) tick();
        switches = 16'h1234; enter_btn = 1'b1; obs_valid = 0;
        repeat (12) tick();
        chk("repress_count", 32'(obs_valid), 32'd1);
        chk("repress_data", in_data, 32'h00001234);
        enter_btn = 1'b0; is_in_instr = 1'b0;

        // Halt in RUN stays halted through presses
        do_reset();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("halt_run", 32'(state), 32'd4);
        enter_btn = 1'b1; is_in_instr = 1'b1; repeat (10) tick();
        enter_btn = 1'b0; is_in_instr = 1'b0; repeat (10) tick();
        chk("halt_sticky_hold", 32'(pc_hold), 32'd1);

        // Halt in WAIT_PRESS
        do_reset();
        is_in_instr = 1'b1; tick(); tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("halt_wait", 32'(state), 32'd4);

        // Halt on the ACCEPT cycle still lets the strobe through
        do_reset();
        is_in_instr = 1'b1; enter_btn = 1'b1; obs_valid = 0;
        wait_state(2, 40, "reach_accept");
        halt_req = 1'b1; tick(); tick(); halt_req = 1'b0;
        chk("halt_accept_state", 32'(state), 32'd4);
        chk("halt_accept_count", 32'(obs_valid), 32'd1);
        enter_btn = 1'b0; is_in_instr = 1'b0;

        // Reset during debounce in WAIT_PRESS
        do_reset();
        is_in_instr = 1'b1; tick(); tick();
        enter_btn = 1'b1; repeat (4) tick();
        reset = 1'b1; obs_valid = 0; tick(); reset = 1'b0;
        chk("rst_mid_state", 32'(state), 32'd0);
        chk("rst_mid_level", 32'(btn_level), 32'd0);
        chk("rst_mid_data", in_data, 32'h0);
        chk("rst_mid_valid", 32'(obs_valid), 32'd0);
        enter_btn = 1'b0; repeat (8) tick();

        // Randomised runs against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            is_in_instr = ($urandom_range(0, 3) != 0);
            halt_req    = ($urandom_range(0, 150) == 0);
            reset       = ($urandom_range(0, 40) == 0);
            enter_btn   = 1'($urandom_range(0, 1));
            switches    = DW'($urandom);
            repeat ($urandom_range(1, 8)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
